// File: rtl/march_sequencer.sv
// march_sequencer: programmable March-test sequencer issuing one memory op per cycle.
// Ports:
//   clk, rst                   clock and asynchronous active-high reset
//   i_start                    start request, sampled only in IDLE
//   i_abort                    terminates the running test (no o_done)
//   i_hold                     pauses the sequence: NOP issued, counters frozen
//   i_num_elem                 number of March elements minus 1
//   i_prog                     element program, element k at bits [12k+11:12k]
//   i_bg                       data background
//   o_op_cmd                   0 NOP, 1 WRITE, 2 READ
//   o_addr_x, o_addr_y         current address (X fast, Y slow)
//   o_data                     write/expect data for the current op
//   o_mbist_run                high while the test is running (including holds)
//   o_done                     one-cycle completion pulse
module march_sequencer #(
    parameter int ADDR_X   = 2,
    parameter int ADDR_Y   = 2,
    parameter int BG_DATA  = 4,
    parameter int MAX_ELEM = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_start,
    input  logic                        i_abort,
    input  logic                        i_hold,
    input  logic [$clog2(MAX_ELEM)-1:0] i_num_elem,
    input  logic [12*MAX_ELEM-1:0]      i_prog,
    input  logic [BG_DATA-1:0]          i_bg,
    output logic [1:0]                  o_op_cmd,
    output logic [ADDR_X-1:0]           o_addr_x,
    output logic [ADDR_Y-1:0]           o_addr_y,
    output logic [BG_DATA-1:0]          o_data,
    output logic                        o_mbist_run,
    output logic                        o_done
);
    localparam int EW = $clog2(MAX_ELEM);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]             r_state;
    logic [12*MAX_ELEM-1:0] r_prog;
    logic [EW-1:0]          r_num_elem;
    logic [BG_DATA-1:0]     r_bg;
    logic [EW-1:0]          r_elem;
    logic [1:0]             r_op;
    logic [ADDR_X-1:0]      r_x;
    logic [ADDR_Y-1:0]      r_y;

    logic [1:0] w_cnt;
    logic       w_dir;
    logic [1:0] w_code;
    logic       w_nxt_dir;
    logic       w_last_op;
    logic       w_x_wrap;
    logic       w_last_addr;

    // Fields of the element currently executing, read straight from the latched program
    assign w_cnt     = r_prog[12*int'(r_elem) +: 2];
    assign w_dir     = r_prog[12*int'(r_elem) + 2];
    assign w_code    = r_prog[12*int'(r_elem) + 4 + 2*int'(r_op) +: 2];
    assign w_nxt_dir = r_prog[12*int'(r_elem + EW'(1)) + 2];
    assign w_last_op = r_op == w_cnt;
    // X wraps at all-ones going up and at zero going down; Y steps only on an X wrap
    assign w_x_wrap    = w_dir ? (r_x == '0) : (r_x == '1);
    assign w_last_addr = w_x_wrap && (w_dir ? (r_y == '0) : (r_y == '1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_prog     <= '0;
            r_num_elem <= '0;
            r_bg       <= '0;
            r_elem     <= '0;
            r_op       <= '0;
            r_x        <= '0;
            r_y        <= '0;
        end else if (r_state == S_IDLE) begin
            if (i_start) begin
                r_state    <= S_RUN;
                r_prog     <= i_prog;
                r_num_elem <= i_num_elem;
                r_bg       <= i_bg;
                r_elem     <= '0;
                r_op       <= '0;
                r_x        <= {ADDR_X{i_prog[2]}};
                r_y        <= {ADDR_Y{i_prog[2]}};
            end
        end else if (r_state == S_DONE) begin
            r_state <= S_IDLE;
        end else if (i_abort) begin
            r_state <= S_IDLE;
        end else if (!i_hold) begin
            if (!w_last_op) begin
                r_op <= r_op + 2'd1;
            end else begin
                r_op <= '0;
                if (!w_last_addr) begin
                    r_x <= w_dir ? r_x - ADDR_X'(1) : r_x + ADDR_X'(1);
                    if (w_x_wrap)
                        r_y <= w_dir ? r_y - ADDR_Y'(1) : r_y + ADDR_Y'(1);
                end else if (r_elem == r_num_elem) begin
                    r_state <= S_DONE;
                end else begin
                    r_elem <= r_elem + EW'(1);
                    r_x    <= {ADDR_X{w_nxt_dir}};
                    r_y    <= {ADDR_Y{w_nxt_dir}};
                end
            end
        end
    end

    // Op code bit 1 selects READ, bit 0 selects the inverted background
    assign o_op_cmd    = (r_state == S_RUN && !i_hold) ? (w_code[1] ? 2'd2 : 2'd1) : 2'd0;
    assign o_addr_x    = r_x;
    assign o_addr_y    = r_y;
    assign o_data      = w_code[0] ? ~r_bg : r_bg;
    assign o_mbist_run = r_state == S_RUN;
    assign o_done      = r_state == S_DONE;
endmodule

// File: tb/tb_march_sequencer.sv
// tb_march_sequencer: randomized self-checking bench for march_sequencer against a list-based model.
module tb_march_sequencer;
    logic        clk = 0, rst = 1, i_start = 0, i_abort = 0, i_hold = 0;
    logic [2:0]  i_num_elem = 0;
    logic [95:0] i_prog = 0;
    logic [3:0]  i_bg = 0;
    logic [1:0]  a_cmd, b_cmd, b_x, b_y;
    logic        a_x, a_y, a_run, a_done, b_run, b_done;
    logic [3:0]  a_d, b_d;
    int          errors = 0, checks = 0;
    bit          sel = 0;
    logic [9:0]  exp_q[$], obs_q[$];
    logic [9:0]  obs;
    logic [1:0]  st;
    localparam logic [95:0] MATS = 96'h035061000;

    march_sequencer #(.ADDR_X(1), .ADDR_Y(1), .BG_DATA(4), .MAX_ELEM(8)) u_a (
        .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort), .i_hold(i_hold),
        .i_num_elem(i_num_elem), .i_prog(i_prog), .i_bg(i_bg), .o_op_cmd(a_cmd),
        .o_addr_x(a_x), .o_addr_y(a_y), .o_data(a_d), .o_mbist_run(a_run), .o_done(a_done));
    march_sequencer #(.ADDR_X(2), .ADDR_Y(2), .BG_DATA(4), .MAX_ELEM(8)) u_b (
        .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort), .i_hold(i_hold),
        .i_num_elem(i_num_elem), .i_prog(i_prog), .i_bg(i_bg), .o_op_cmd(b_cmd),
        .o_addr_x(b_x), .o_addr_y(b_y), .o_data(b_d), .o_mbist_run(b_run), .o_done(b_done));

    always #5 clk = ~clk;
    assign obs = sel ? {b_cmd, b_x, b_y, b_d} : {a_cmd, 1'b0, a_x, 1'b0, a_y, a_d};
    assign st  = sel ? {b_run, b_done} : {a_run, a_done};

    // Expected op list: element outermost, linear address (X fast) reversed for down, op innermost
    task automatic build(input logic [95:0] prog, input int num, input logic [3:0] bg, input int aw);
        int n;
        logic [11:0] el;
        logic [1:0] code;
        exp_q.delete();
        n = 1 << (2 * aw);
        for (int e = 0; e <= num; e++) begin
            el = prog[12*e +: 12];
            for (int a = 0; a < n; a++) begin
                int ad, x, y;
                ad = el[2] ? n - 1 - a : a;
                x = ad % (1 << aw);
                y = ad >> aw;
                for (int o = 0; o <= int'(el[1:0]); o++) begin
                    code = el[4+2*o +: 2];
                    exp_q.push_back({code[1] ? 2'd2 : 2'd1, 2'(x), 2'(y), code[0] ? ~bg : bg});
                end
            end
        end
    endtask

    task automatic run_seq(input logic [95:0] prog, input int num, input logic [3:0] bg,
                           input int hold_at, input int hold_len, input int abort_at, input bit glitch);
        int idx, hl;
        logic [9:0] e;
        build(prog, num, bg, sel ? 2 : 1);
        obs_q.delete();
        i_prog = prog; i_num_elem = 3'(num); i_bg = bg; i_start = 1;
        @(posedge clk); #1;
        i_start = 0;
        i_prog = {$urandom, $urandom, $urandom}; i_num_elem = 3'($urandom); i_bg = 4'($urandom);
        idx = 0; hl = hold_len;
        while (idx < exp_q.size()) begin
            i_hold  = (hold_at == idx) && (hl > 0);
            i_abort = (abort_at == idx) && !i_hold;
            i_start = glitch ? 1'($urandom) : 1'b0;
            @(negedge clk);
            e = i_hold ? {2'd0, exp_q[idx][7:0]} : exp_q[idx];
            checks++;
            if (obs !== e) begin errors++; $display("FAIL op[%0d] hold=%0b: got %h expected %h", idx, i_hold, obs, e); end
            checks++;
            if (st !== 2'b10) begin errors++; $display("FAIL run_status[%0d]: got %b expected 10", idx, st); end
            if (!i_hold) obs_q.push_back(obs);
            @(posedge clk); #1;
            if (i_hold) hl--;
            else if (i_abort) begin
                i_abort = 0; i_start = 0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    checks++;
                    if ({obs[9:8], st} !== 4'b0000) begin errors++; $display("FAIL abort[%0d]: got cmd %0d st %b expected cmd 0 st 00", k, obs[9:8], st); end
                    @(posedge clk); #1;
                end
                return;
            end else idx++;
        end
        i_hold = 0; i_start = 0;
        @(negedge clk);
        checks++;
        if ({obs[9:8], st} !== 4'b0001) begin errors++; $display("FAIL done_pulse: got cmd %0d st %b expected cmd 0 st 01", obs[9:8], st); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({obs[9:8], st} !== 4'b0000) begin errors++; $display("FAIL after_done: got cmd %0d st %b expected cmd 0 st 00", obs[9:8], st); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({a_cmd, a_x, a_y, a_d, a_run, a_done} !== 12'h0) begin errors++; $display("FAIL reset_a: got %h expected 000", {a_cmd, a_x, a_y, a_d, a_run, a_done}); end
        checks++;
        if ({b_cmd, b_x, b_y, b_d, b_run, b_done} !== 14'h0) begin errors++; $display("FAIL reset_b: got %h expected 0000", {b_cmd, b_x, b_y, b_d, b_run, b_done}); end
        @(posedge clk); #1;
        rst = 0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (st !== 2'b00) begin errors++; $display("FAIL idle_after_reset: got %b expected 00", st); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mats;
        sel = 0;
        run_seq(MATS, 2, 4'h5, -1, 0, -1, 0);
        checks++;
        if (obs_q[4] !== {2'd2, 2'd0, 2'd0, 4'h5}) begin errors++; $display("FAIL mats_cycle5: got %h expected %h", obs_q[4], {2'd2, 2'd0, 2'd0, 4'h5}); end
        checks++;
        if (obs_q[5] !== {2'd1, 2'd0, 2'd0, 4'hA}) begin errors++; $display("FAIL mats_cycle6: got %h expected %h", obs_q[5], {2'd1, 2'd0, 2'd0, 4'hA}); end
        checks++;
        if (obs_q[12] !== {2'd2, 2'd1, 2'd1, 4'hA}) begin errors++; $display("FAIL mats_cycle13: got %h expected %h", obs_q[12], {2'd2, 2'd1, 2'd1, 4'hA}); end
    endtask

    task automatic test_hold;
        sel = 0;
        run_seq(MATS, 2, 4'h5, 6, 3, -1, 0);
    endtask

    task automatic test_abort;
        sel = 0;
        run_seq(MATS, 2, 4'h5, -1, 0, 9, 0);
        run_seq(MATS, 2, 4'h5, -1, 0, -1, 0);
        checks++;
        if (obs_q[0] !== {2'd1, 2'd0, 2'd0, 4'h5}) begin errors++; $display("FAIL restart_first_op: got %h expected %h", obs_q[0], {2'd1, 2'd0, 2'd0, 4'h5}); end
    endtask

    task automatic test_up_w1;
        logic [3:0] bg;
        rst = 1; @(posedge clk); #1; rst = 0;
        sel = 1;
        bg = 4'($urandom);
        run_seq(96'h010, 0, bg, -1, 0, -1, 1);
        checks++;
        if (obs_q[4] !== {2'd1, 2'd0, 2'd1, ~bg}) begin errors++; $display("FAIL upw1_cycle5: got %h expected %h", obs_q[4], {2'd1, 2'd0, 2'd1, ~bg}); end
    endtask

    task automatic test_random;
        sel = 1;
        for (int t = 0; t < 6; t++)
            run_seq({$urandom, $urandom, $urandom}, int'($urandom_range(0, 3)), 4'($urandom),
                    int'($urandom_range(0, 20)), int'($urandom_range(0, 3)), -1, 1);
    endtask

    task automatic test_reset_mid;
        sel = 1;
        i_prog = MATS; i_num_elem = 3'd2; i_bg = 4'h5; i_start = 1;
        @(posedge clk); #1;
        i_start = 0;
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (st !== 2'b10) begin errors++; $display("FAIL pre_reset_run: got %b expected 10", st); end
        rst = 1;
        #1;
        checks++;
        if ({b_cmd, b_x, b_y, b_d, b_run, b_done} !== 14'h0) begin errors++; $display("FAIL reset_mid_b: got %h expected 0000", {b_cmd, b_x, b_y, b_d, b_run, b_done}); end
        checks++;
        if ({a_cmd, a_x, a_y, a_d, a_run, a_done} !== 12'h0) begin errors++; $display("FAIL reset_mid_a: got %h expected 000", {a_cmd, a_x, a_y, a_d, a_run, a_done}); end
        @(posedge clk); #1;
        rst = 0;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if ({obs[9:8], st} !== 4'b0000) begin errors++; $display("FAIL idle_after_mid_reset: got cmd %0d st %b expected cmd 0 st 00", obs[9:8], st); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset;
        test_mats;
        test_hold;
        test_abort;
        test_up_w1;
        test_random;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/march_sequencer.md
MARCH_SEQUENCER -- requirements
Module: march_sequencer

Interface
REQ-001 SHALL have parameter ADDR_X, default 2: X address width.
REQ-002 SHALL have parameter ADDR_Y, default 2: Y address width.
REQ-003 SHALL have parameter BG_DATA, default 4: data background width.
REQ-004 SHALL have parameter MAX_ELEM, default 8: maximum March elements per program.
REQ-005 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port i_start, input, 1: start request, sampled only in IDLE.
REQ-008 SHALL have port i_abort, input, 1: terminate the running test.
REQ-009 SHALL have port i_hold, input, 1: pause the sequence (retention or shift).
REQ-010 SHALL have port i_num_elem, input, $clog2(MAX_ELEM): element count minus 1.
REQ-011 SHALL have port i_prog, input, 12*MAX_ELEM: element k at bits [12k+11:12k].
REQ-012 SHALL have port i_bg, input, BG_DATA: data background.
REQ-013 SHALL have port o_op_cmd, output, 2: 0 NOP, 1 WRITE, 2 READ (matches the ctrl_sigs_gen command encoding).
REQ-014 SHALL have port o_addr_x, output, ADDR_X: X address.
REQ-015 SHALL have port o_addr_y, output, ADDR_Y: Y address.
REQ-016 SHALL have port o_data, output, BG_DATA: write/expect data.
REQ-017 SHALL have port o_mbist_run, output, 1: test active.
REQ-018 SHALL have port o_done, output, 1: completion pulse.

Function
REQ-019 Element encoding SHALL be: [1:0] op count minus 1; [2] direction (0 up, 1 down); [3] reserved, ignored; [11:4] op0..op3, 2 bits each, op0 in [5:4].
REQ-020 Op codes SHALL be: 00 W0, 01 W1, 10 R0, 11 R1.
REQ-021 Ops SHALL map to commands and data: W0 = WRITE with o_data = i_bg; W1 = WRITE with ~i_bg; R0 = READ with i_bg; R1 = READ with ~i_bg.
REQ-022 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-023 IDLE -> RUN SHALL occur when i_start=1; i_prog, i_num_elem and i_bg are latched at that edge.
REQ-024 Input changes after the latching edge SHALL have no effect on the running test.
REQ-025 The first op SHALL appear in the cycle after i_start is sampled; latency is 1.
REQ-026 In RUN, exactly one op SHALL be issued per cycle, on o_op_cmd, o_addr_x, o_addr_y and o_data together.
REQ-027 Iteration order SHALL be:
  - element outermost;
  - then address;
  - then op index, innermost.
  Within each address, all ops of the element are issued in order op0..opN.
REQ-028 Address order SHALL have X fast and Y slow.
  - Up: (x,y) = (0,0), (1,0) ... (max,0), (0,1) ... (max,max).
  - Down: the exact reverse of up.
REQ-029 Element-to-element transition SHALL be seamless: no NOP cycle between elements.
REQ-030 Address SHALL reset to the start address of the new element's direction on each element transition.
REQ-031 After the last op of the last address of element i_num_elem, the FSM SHALL enter DONE.
REQ-032 In DONE: o_op_cmd = NOP and o_done = 1 for exactly one cycle, then IDLE.
REQ-033 o_mbist_run SHALL be 1 exactly while in RUN (including hold cycles) and 0 in IDLE and DONE.
REQ-034 i_hold=1 in RUN SHALL force o_op_cmd = NOP and freeze all counters.
  - o_addr_x, o_addr_y and o_data hold their values.
  - Sequencing resumes with the frozen op in the cycle after i_hold falls.
  - i_hold has no effect in IDLE or DONE.
REQ-035 i_abort=1 in RUN SHALL move the FSM to IDLE at that edge.
  - Next cycle: NOP with o_mbist_run = 0, and no o_done pulse.
  - i_abort takes priority over i_hold and over completion.
REQ-036 i_start SHALL be ignored in RUN and DONE.
REQ-037 Address counters SHALL be exactly ADDR_X and ADDR_Y bits wide.
  - Wrap detection compares against all-ones (up) or zero (down).
  - No counter overflows into the other.
REQ-038 Total op cycles SHALL be sum over elements of (op count × 2^(ADDR_X+ADDR_Y)), excluding hold cycles.

Reset
REQ-039 rst=1 SHALL asynchronously force:
  - state IDLE;
  - o_op_cmd = NOP;
  - o_addr_x = 0 and o_addr_y = 0;
  - o_data = 0;
  - o_mbist_run = 0 and o_done = 0;
  - all internal counters and latched program to 0.
REQ-040 Reset asserted mid-RUN SHALL abandon the test with no o_done; after rst falls, the block waits in IDLE for a new i_start.

Verification
REQ-041 MATS+ test, ADDR_X=ADDR_Y=1, i_bg=4'h5, elements up(W0), up(R0,W1), down(R1,W0), i_num_elem=2:
  - 20 consecutive op cycles starting 1 cycle after i_start;
  - the 5th cycle is READ at (0,0) with data 5, and the 6th is WRITE at (0,0) with data A;
  - the 13th cycle is READ at (1,1) with data A;
  - o_done pulses in the 21st cycle.
REQ-042 Hold, same program: i_hold=1 for 3 cycles starting at op cycle 7:
  - 3 NOP cycles while address and data stay frozen;
  - op 7 issued after hold falls;
  - o_done delayed by exactly 3 cycles.
REQ-043 Abort, same program: i_abort at op cycle 10:
  - next cycle NOP with o_mbist_run=0;
  - no o_done;
  - a fresh i_start restarts from element 0, address (0,0).
REQ-044 Single-element up(W1), ADDR_X=ADDR_Y=2:
  - 16 writes of ~i_bg;
  - x fast: (0,0),(1,0),(2,0),(3,0),(0,1)...(3,3);
  - i_start pulses during RUN are ignored.
REQ-045 Reset mid-RUN (rst at op cycle 4):
  - all outputs 0 immediately, without waiting for clk;
  - no o_done;
  - block IDLE after release.
